// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: command codes, FSM states and shared constants for the JK bank driver
package jk_drv_pkg;
    localparam logic [1:0] CMD_WR  = 2'b00;
    localparam logic [1:0] CMD_PRE = 2'b01;
    localparam logic [1:0] CMD_CLR = 2'b10;
    localparam logic [1:0] CMD_TOG = 2'b11;
    localparam int SYNC_DEPTH = 2;
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, ASYNC, SYNC, CHECK} state_t;
    function automatic logic is_async(input logic [1:0] c);
        return c == CMD_PRE || c == CMD_CLR;
    endfunction
endpackage

// File: rtl/jk_excite.sv
// jk_excite: per-bit JK excitation steering each bit toward its target, or toggling all bits
module jk_excite #(
    parameter int N = 4
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] t,
    input  logic         tog,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);
    always_comb begin
        j = {N{tog}} | (t & ~q);
        k = {N{tog}} | (~t & q);
    end
endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: strobes a negedge JK flip-flop bank per command and confirms the result via Q readback
module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int N          = 4,
    parameter int STROBE_LEN = 2,
    parameter int MAX_RETRY  = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [1:0]   cmd,
    input  logic [N-1:0] din,
    input  logic         valid,
    output logic         ready,
    input  logic [N-1:0] qfb,
    output logic [N-1:0] jo,
    output logic [N-1:0] ko,
    output logic         fclk,
    output logic         pren,
    output logic         clrn,
    output logic [N-1:0] qexp,
    output logic         done,
    output logic         err
);
    localparam int CW = $clog2((STROBE_LEN > SYNC_DEPTH ? STROBE_LEN : SYNC_DEPTH) + 1);
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    state_t state, state_n;
    logic [1:0] cmd_r, cmd_n;
    logic [N-1:0] q1, qs, ej, ek, qexp_n, jo_n, ko_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [RW-1:0] retry, retry_n;
    logic accept, fclk_n, pren_n, clrn_n, done_n, err_n;
    assign ready  = rstn && state == IDLE;
    assign accept = valid && ready;
    // First pass of a toggle flips every bit; retries steer each bit toward QEXP instead
    jk_excite #(.N(N)) u_excite (
        .q  (qs),
        .t  (accept ? din : qexp),
        .tog(accept && cmd == CMD_TOG),
        .j  (ej),
        .k  (ek)
    );
    always_comb begin
        state_n = state;
        cmd_n   = cmd_r;
        cnt_n   = cnt;
        retry_n = retry;
        qexp_n  = qexp;
        err_n   = err;
        done_n  = 1'b0;
        case (state)
            IDLE: if (accept) begin
                cmd_n   = cmd;
                qexp_n  = cmd == CMD_WR ? din : cmd == CMD_PRE ? '1 : cmd == CMD_CLR ? '0 : ~qs;
                err_n   = 1'b0;
                retry_n = '0;
                cnt_n   = CW'(STROBE_LEN - 1);
                state_n = is_async(cmd) ? ASYNC : SETUP;
            end
            SETUP: state_n = STROBE;
            STROBE: begin
                state_n = cnt == '0 ? RELEASE : STROBE;
                cnt_n   = cnt - CW'(1);
            end
            RELEASE: begin
                state_n = SYNC;
                cnt_n   = CW'(SYNC_DEPTH - 1);
            end
            ASYNC: begin
                state_n = cnt == '0 ? SYNC : ASYNC;
                cnt_n   = cnt == '0 ? CW'(SYNC_DEPTH - 1) : cnt - CW'(1);
            end
            SYNC: begin
                state_n = cnt == '0 ? CHECK : SYNC;
                cnt_n   = cnt - CW'(1);
            end
            CHECK: if (qs == qexp) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end else if (retry < RW'(MAX_RETRY)) begin
                retry_n = retry + RW'(1);
                cnt_n   = CW'(STROBE_LEN - 1);
                state_n = is_async(cmd_r) ? ASYNC : SETUP;
            end else begin
                err_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        fclk_n = state_n != STROBE;
        pren_n = !(state_n == ASYNC && cmd_n == CMD_PRE);
        clrn_n = !(state_n == ASYNC && cmd_n == CMD_CLR);
        jo_n   = state_n == SETUP ? ej : (state_n == STROBE || state_n == RELEASE) ? jo : '0;
        ko_n   = state_n == SETUP ? ek : (state_n == STROBE || state_n == RELEASE) ? ko : '0;
    end
    always_ff @(posedge clk) begin
        q1 <= qfb;
        qs <= q1;
    end
    // Pin outputs are registered so the bank never sees decode glitches on FCLK/PREn/CLRn
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cmd_r <= CMD_WR;
            cnt   <= '0;
            retry <= '0;
            qexp  <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
            fclk  <= 1'b1;
            pren  <= 1'b1;
            clrn  <= 1'b1;
            jo    <= '0;
            ko    <= '0;
        end else begin
            state <= state_n;
            cmd_r <= cmd_n;
            cnt   <= cnt_n;
            retry <= retry_n;
            qexp  <= qexp_n;
            err   <= err_n;
            done  <= done_n;
            fclk  <= fclk_n;
            pren  <= pren_n;
            clrn  <= clrn_n;
            jo    <= jo_n;
            ko    <= ko_n;
        end
    end
endmodule
